// File: rtl/alu_sequencer.sv
// Multi-cycle controller that sequences the shared combinational ALU for one instruction:
// operand reads from a single-port register file, execute, write-back and flag update.
module alu_sequencer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned OPC_W   = 8,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned FLAG_W  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    // request interface
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [OPC_W-1:0]   i_req_opcode,
    input  logic [RADDR_W-1:0] i_req_rdest,
    input  logic [RADDR_W-1:0] i_req_rsrc,
    input  logic [DATA_W-1:0]  i_req_imm,
    input  logic               i_req_use_imm,
    input  logic               i_req_wb,
    // register file
    output logic [RADDR_W-1:0] o_rf_raddr,
    input  logic [DATA_W-1:0]  i_rf_rdata,
    output logic               o_rf_we,
    output logic [RADDR_W-1:0] o_rf_waddr,
    output logic [DATA_W-1:0]  o_rf_wdata,
    // ALU
    output logic [DATA_W-1:0]  o_alu_a,
    output logic [DATA_W-1:0]  o_alu_b,
    output logic [OPC_W-1:0]   o_alu_opcode,
    output logic               o_alu_carry_in,
    input  logic [DATA_W-1:0]  i_alu_result,
    input  logic [FLAG_W-1:0]  i_alu_flags,
    // status
    output logic [FLAG_W-1:0]  o_psr_flags,
    output logic               o_done
);

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StExec, StWb} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;

    logic [RADDR_W-1:0]   r_rdest;
    logic [RADDR_W-1:0]   r_rsrc;
    logic [DATA_W-1:0]    r_imm;
    logic                 r_use_imm;
    logic                 r_wb;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [OPC_W-1:0]     r_alu_opcode;
    logic [DATA_W-1:0]    r_result;
    logic [FLAG_W-1:0]    r_flags;
    logic [FLAG_W-1:0]    r_psr;

    assign w_accept = i_req_valid && (r_state == StIdle);

    // Next-state selection and decoded control outputs.
    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        o_rf_raddr   = '0;
        o_rf_we      = 1'b0;
        o_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_req_ready = 1'b1;
                // Operand A read is launched on the accept edge itself.
                o_rf_raddr  = i_req_rdest;
                if (w_accept) w_state_next = StRdA;
            end
            StRdA: begin
                o_rf_raddr   = r_rsrc;
                w_state_next = r_use_imm ? StExec : StRdB;
            end
            StRdB:  w_state_next = StExec;
            StExec: w_state_next = StWb;
            StWb: begin
                o_rf_we      = r_wb;
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        if (i_reset) o_rf_raddr = '0;
    end

    // State register plus request latch, operand capture, result capture and flag update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_rdest      <= '0;
            r_rsrc       <= '0;
            r_imm        <= '0;
            r_use_imm    <= 1'b0;
            r_wb         <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_result     <= '0;
            r_flags      <= '0;
            r_psr        <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_alu_opcode <= i_req_opcode;
                        r_rdest      <= i_req_rdest;
                        r_rsrc       <= i_req_rsrc;
                        r_imm        <= i_req_imm;
                        r_use_imm    <= i_req_use_imm;
                        r_wb         <= i_req_wb;
                    end
                end
                StRdA: begin
                    r_alu_a <= i_rf_rdata;
                    if (r_use_imm) r_alu_b <= r_imm;
                end
                StRdB:  r_alu_b <= i_rf_rdata;
                StExec: begin
                    r_result <= i_alu_result;
                    r_flags  <= i_alu_flags;
                end
                StWb:   r_psr <= r_flags;
                default: ;
            endcase
        end
    end

    assign o_rf_waddr     = r_rdest;
    assign o_rf_wdata     = r_result;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_alu_opcode   = r_alu_opcode;
    assign o_psr_flags    = r_psr;
    // Carry chains from the previous completed operation.
    assign o_alu_carry_in = r_psr[0];

endmodule
